board_event_processor: RTL and testbench

//  Consumes game_logic's turn-result outputs (pos_valid, event_flag, winner_valid) and runs the board-square

---
 rtl/dice_race_pkg.sv | 46 ++++
 rtl/board_event_processor_if.sv | 30 +++
 rtl/sec_tick_gen.sv | 25 ++
 rtl/board_event_processor.sv | 125 ++++++++++++
 tb/tb_board_event_processor.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dice_race_pkg.sv
// Shared types for the dice-race board: video filter codes, board event codes and event FSM states.
package dice_race_pkg;

  localparam int unsigned EV_W  = 4;
  localparam int unsigned SEC_W = 4;

  typedef enum logic [2:0] {
    F_NONE,
    F_GRAY,
    F_INVERT,
    F_MOSAIC,
    F_MIRROR,
    F_RAINBOW
  } filter_t;

  localparam logic [EV_W-1:0] EV_NONE    = 4'd0;
  localparam logic [EV_W-1:0] EV_GRAY    = 4'd2;
  localparam logic [EV_W-1:0] EV_BACK    = 4'd3;
  localparam logic [EV_W-1:0] EV_MOSAIC  = 4'd4;
  localparam logic [EV_W-1:0] EV_MIRROR  = 4'd6;
  localparam logic [EV_W-1:0] EV_RAINBOW = 4'd8;
  localparam logic [EV_W-1:0] EV_WIN     = 4'd10;

  typedef logic [1:0] evt_state_t;
  localparam evt_state_t S_IDLE = 2'd0;
  localparam evt_state_t S_RUN  = 2'd1;
  localparam evt_state_t S_END  = 2'd2;
  localparam evt_state_t S_WIN  = 2'd3;

  // Square events that run a timed filter; other nonzero codes end immediately.
  function automatic logic is_square_event(input logic [EV_W-1:0] code);
    return code inside {EV_GRAY, EV_BACK, EV_MOSAIC, EV_MIRROR, EV_RAINBOW};
  endfunction

  function automatic filter_t event_filter(input logic [EV_W-1:0] code);
    case (code)
      EV_GRAY:    return F_GRAY;
      EV_BACK:    return F_INVERT;
      EV_MOSAIC:  return F_MOSAIC;
      EV_MIRROR:  return F_MIRROR;
      EV_RAINBOW: return F_RAINBOW;
      default:    return F_NONE;
    endcase
  endfunction

endpackage

// File: rtl/board_event_processor_if.sv
// Turn-result inputs from game_logic and event/filter outputs toward the pixel pipeline.
// skip_btn exists only when EVENT_SKIP_EN is defined.
interface board_event_processor_if;
  import dice_race_pkg::*;

  logic              pos_valid;
  logic [EV_W-1:0]   event_flag;
  logic              winner_valid;
`ifdef EVENT_SKIP_EN
  logic              skip_btn;
`endif
  logic              event_active;
  logic [EV_W-1:0]   event_id;
  filter_t           filter_sel;
  logic [SEC_W-1:0]  sec_left;
  logic              event_end_tick;

`ifdef EVENT_SKIP_EN
  modport master (output pos_valid, event_flag, winner_valid, skip_btn,
                  input  event_active, event_id, filter_sel, sec_left, event_end_tick);
  modport slave  (input  pos_valid, event_flag, winner_valid, skip_btn,
                  output event_active, event_id, filter_sel, sec_left, event_end_tick);
`else
  modport master (output pos_valid, event_flag, winner_valid,
                  input  event_active, event_id, filter_sel, sec_left, event_end_tick);
  modport slave  (input  pos_valid, event_flag, winner_valid,
                  output event_active, event_id, filter_sel, sec_left, event_end_tick);
`endif

endinterface

// File: rtl/sec_tick_gen.sv
// One-cycle tick every CLK_HZ cycles; clear holds the count at zero so the
// first tick after clear drops lands CLK_HZ cycles later.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = ~clear & (count == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                count <= '0;
    else if (clear || tick_c) count <= '0;
    else                      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/board_event_processor.sv
// Runs the board-square event after each turn: drives a timed video filter and
// pulses event_end_tick when done. EVENT_SKIP_EN adds skip_btn to end a running event early.
module board_event_processor
  import dice_race_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned EVENT_SEC = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  board_event_processor_if.slave    bus
);

  localparam logic [SEC_W-1:0] SEC_INIT = SEC_W'(EVENT_SEC);

  evt_state_t        state;
  evt_state_t        state_n;
  logic              pos_valid_d;
  logic              trig_c;
  logic              skip_c;
  logic              sec_tick_c;
  logic              sec_clear_c;
  logic              go_end_c;
  logic              active_n;
  logic [EV_W-1:0]   id_n;
  filter_t           filter_n;
  logic [SEC_W-1:0]  sec_n;
  logic              end_tick_n;

  // game_logic signals a finished turn with the falling edge of pos_valid.
  assign trig_c      = pos_valid_d & ~bus.pos_valid;
  assign sec_clear_c = (state != S_RUN);

`ifdef EVENT_SKIP_EN
  assign skip_c = bus.skip_btn;
`else
  assign skip_c = 1'b0;
`endif

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (sec_clear_c),
    .tick_c (sec_tick_c)
  );

  always_comb begin
    state_n    = state;
    active_n   = bus.event_active;
    id_n       = bus.event_id;
    filter_n   = bus.filter_sel;
    sec_n      = bus.sec_left;
    end_tick_n = 1'b0;
    go_end_c   = 1'b0;

    case (state)
      S_IDLE: begin
        if (trig_c) begin
          if (bus.winner_valid) begin
            state_n  = S_WIN;
            active_n = 1'b1;
            id_n     = EV_WIN;
            filter_n = F_RAINBOW;
            sec_n    = '0;
          end else if (is_square_event(bus.event_flag)) begin
            state_n  = S_RUN;
            active_n = 1'b1;
            id_n     = bus.event_flag;
            filter_n = event_filter(bus.event_flag);
            sec_n    = SEC_INIT;
          end else if (bus.event_flag != EV_NONE) begin
            go_end_c = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (skip_c || (sec_tick_c && (bus.sec_left == SEC_W'(1)))) begin
          go_end_c = 1'b1;
        end else if (sec_tick_c) begin
          sec_n = bus.sec_left - SEC_W'(1);
        end
      end
      S_END: begin
        state_n = S_IDLE;
      end
      S_WIN: begin
        state_n = S_WIN;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Completing (or bypassing) an event restores idle outputs alongside the end pulse.
    if (go_end_c) begin
      state_n    = S_END;
      active_n   = 1'b0;
      id_n       = EV_NONE;
      filter_n   = F_NONE;
      sec_n      = '0;
      end_tick_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      pos_valid_d        <= 1'b0;
      bus.event_active   <= 1'b0;
      bus.event_id       <= EV_NONE;
      bus.filter_sel     <= F_NONE;
      bus.sec_left       <= '0;
      bus.event_end_tick <= 1'b0;
    end else begin
      state              <= state_n;
      pos_valid_d        <= bus.pos_valid;
      bus.event_active   <= active_n;
      bus.event_id       <= id_n;
      bus.filter_sel     <= filter_n;
      bus.sec_left       <= sec_n;
      bus.event_end_tick <= end_tick_n;
    end
  end

endmodule

// File: tb/tb_board_event_processor.sv
// Randomized bench for board_event_processor with an event-timeline reference model
// and an end-tick scoreboard; exercises skip_btn when EVENT_SKIP_EN is defined.
module tb_board_event_processor;
  import dice_race_pkg::*;

  localparam int CLK_HZ    = 10;
  localparam int EVENT_SEC = 3;
  localparam int RUN_CYC   = CLK_HZ * EVENT_SEC;
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_WIN     = 2;

  logic clk = 1'b0;
  logic reset;

  board_event_processor_if bif ();

  board_event_processor #(.CLK_HZ(CLK_HZ), .EVENT_SEC(EVENT_SEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference timeline of the current event: outputs shown from m_start,
  // end pulse at m_end (m_end == m_start for codes that end immediately).
  int          m_mode  = M_IDLE;
  int          m_start = -10;
  int          m_end   = -10;
  logic [3:0]  m_flag  = 4'd0;
  int          exp_tick_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit final_req  = 1'b0;
  bit final_done = 1'b0;

  function automatic bit ref_square(input logic [3:0] f);
    return (f == 4'd2) || (f == 4'd3) || (f == 4'd4) || (f == 4'd6) || (f == 4'd8);
  endfunction

  function automatic filter_t ref_filter(input logic [3:0] f);
    case (f)
      4'd2:    return F_GRAY;
      4'd3:    return F_INVERT;
      4'd4:    return F_MOSAIC;
      4'd6:    return F_MIRROR;
      4'd8:    return F_RAINBOW;
      default: return F_NONE;
    endcase
  endfunction

  // Monitor: compares every cycle's outputs to the timeline and pops the scoreboard on end pulses.
  always @(negedge clk) begin : monitor
    logic       exp_act;
    logic [3:0] exp_id;
    filter_t    exp_f;
    logic [3:0] exp_sec;
    logic       exp_tick;
    int         want;
    exp_act  = 1'b0;
    exp_id   = 4'd0;
    exp_f    = F_NONE;
    exp_sec  = 4'd0;
    exp_tick = 1'b0;
    if (m_mode == M_WIN && cyc >= m_start) begin
      exp_act = 1'b1;
      exp_id  = 4'd10;
      exp_f   = F_RAINBOW;
    end else if (m_mode == M_RUN) begin
      if (cyc >= m_start && cyc < m_end) begin
        exp_act = 1'b1;
        exp_id  = m_flag;
        exp_f   = ref_filter(m_flag);
        exp_sec = 4'(EVENT_SEC - (cyc - m_start) / CLK_HZ);
      end else if (cyc == m_end) begin
        exp_tick = 1'b1;
      end
    end
    n_checks++;
    if ({bif.event_active, bif.event_id, bif.filter_sel, bif.sec_left, bif.event_end_tick} !==
        {exp_act, exp_id, exp_f, exp_sec, exp_tick}) begin
      n_fail++;
      $display("FAIL outputs @%0d: got act=%0b id=%0d filt=%0d sec=%0d tick=%0b, want act=%0b id=%0d filt=%0d sec=%0d tick=%0b",
               cyc, bif.event_active, bif.event_id, bif.filter_sel, bif.sec_left, bif.event_end_tick,
               exp_act, exp_id, exp_f, exp_sec, exp_tick);
    end
    if (bif.event_end_tick === 1'b1) begin
      n_checks++;
      if (exp_tick_q.size() == 0) begin
        n_fail++;
        $display("FAIL end_tick @%0d: got unexpected pulse, want none", cyc);
      end else begin
        want = exp_tick_q.pop_front();
        if (want != cyc) begin
          n_fail++;
          $display("FAIL end_tick_time: got cycle %0d, want cycle %0d", cyc, want);
        end
      end
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      n_checks++;
      if (exp_tick_q.size() != 0) begin
        n_fail++;
        $display("FAIL pending_ticks: got %0d undelivered end ticks, want 0", exp_tick_q.size());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.pos_valid = 1'b0;
`ifdef EVENT_SKIP_EN
    bif.skip_btn = 1'b0;
`endif
    m_mode  = M_IDLE;
    m_start = -10;
    m_end   = -10;
    exp_tick_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic try_skip();
`ifdef EVENT_SKIP_EN
    bif.skip_btn = 1'b1;
    if (m_mode == M_RUN && cyc >= m_start && cyc < m_end && exp_tick_q.size() > 0) begin
      m_end = cyc + 1;
      exp_tick_q[exp_tick_q.size()-1] = m_end;
    end
`endif
  endtask

  // Let the current event finish while throwing ignored pos_valid edges (and maybe skip/reset) at it.
  task automatic wait_idle(input bit allow_reset);
    while (m_mode == M_RUN && cyc <= m_end) begin
      step();
`ifdef EVENT_SKIP_EN
      bif.skip_btn = 1'b0;
      if ($urandom_range(0, 24) == 0) try_skip();
`endif
      if (allow_reset && $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bif.pos_valid  = (cyc < m_end - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bif.event_flag = 4'($urandom_range(0, 15));
      end
    end
`ifdef EVENT_SKIP_EN
    bif.skip_btn = 1'b0;
`endif
  endtask

  task automatic trigger(input logic [3:0] flag, input logic win);
    wait_idle(1'b0);
    repeat ($urandom_range(1, 4)) begin
      step();
      bif.pos_valid    = 1'b1;
      bif.event_flag   = 4'($urandom_range(0, 15));
      bif.winner_valid = 1'($urandom_range(0, 1));
    end
    step();
    bif.pos_valid    = 1'b0;
    bif.event_flag   = flag;
    bif.winner_valid = win;
    m_start = cyc + 1;
    if (win) begin
      m_mode = M_WIN;
    end else if (ref_square(flag)) begin
      m_mode = M_RUN;
      m_flag = flag;
      m_end  = m_start + RUN_CYC;
      exp_tick_q.push_back(m_end);
    end else if (flag != 4'd0) begin
      m_mode = M_RUN;
      m_flag = flag;
      m_end  = m_start;
      exp_tick_q.push_back(m_end);
    end
  endtask

  initial begin
    logic [3:0] f;
    reset            = 1'b1;
    bif.pos_valid    = 1'b0;
    bif.event_flag   = 4'd0;
    bif.winner_valid = 1'b0;
`ifdef EVENT_SKIP_EN
    bif.skip_btn     = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;

    trigger(4'd2, 1'b0);
    trigger(4'd0, 1'b0);
    repeat (40) step();

    trigger(4'd6, 1'b0);
    while (cyc < m_start + 14) step();
    do_reset();
    repeat (40) step();

    trigger(4'd5, 1'b0);
    trigger(4'd10, 1'b0);

`ifdef EVENT_SKIP_EN
    trigger(4'd8, 1'b0);
    while (cyc < m_start + 6) step();
    try_skip();
    step();
    bif.skip_btn = 1'b0;
    trigger(4'd8, 1'b0);
`endif

    repeat (30) begin
      if ($urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 4))
          0: f = 4'd2;
          1: f = 4'd3;
          2: f = 4'd4;
          3: f = 4'd6;
          default: f = 4'd8;
        endcase
      end else begin
        f = 4'($urandom_range(0, 15));
      end
      trigger(f, 1'b0);
      wait_idle(1'b1);
    end
    wait_idle(1'b0);

    trigger(4'd4, 1'b1);
    repeat (200) begin
      step();
      bif.pos_valid    = 1'($urandom_range(0, 1));
      bif.event_flag   = 4'($urandom_range(0, 15));
      bif.winner_valid = 1'($urandom_range(0, 1));
`ifdef EVENT_SKIP_EN
      bif.skip_btn     = 1'($urandom_range(0, 1));
`endif
    end
`ifdef EVENT_SKIP_EN
    bif.skip_btn = 1'b0;
`endif

    final_req = 1'b1;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
